// File: rtl/riscv_pkg.sv
// Shared RISC-V pipeline types: fetch-to-decode packet and the canonical NOP encoding.
package riscv_pkg;

  localparam int XLEN = 32;

  // addi x0,x0,0; presented to decode whenever no real packet is available
  localparam logic [31:0] NOP_INSTR = 32'h0000_0013;

  typedef struct packed {
    logic [XLEN-1:0] pc;
    logic [31:0]     instruction;
    logic [XLEN-1:0] pc_plus4;
    logic            valid_if_id;
  } if_id_reg_t;

endpackage

// File: rtl/if_id_queue.sv
// In-order fetch->decode packet queue with taken-branch flush; a push is visible on id_out the cycle after.
// Back-pressure: pc_stall = full (registered state only); flush drops all entries and the incoming packet.
module if_id_queue
  import riscv_pkg::*;
#(
  parameter int DEPTH = 4,
  parameter int CNT_W = $clog2(DEPTH + 1)
) (
  input  logic             clk,
  input  logic             reset,
  input  if_id_reg_t       if_in,
  input  logic             flush,
  input  logic             id_ready,
  output if_id_reg_t       id_out,
  output logic             pc_stall,
  output logic [CNT_W-1:0] count
);

  localparam int PTR_W = $clog2(DEPTH);

  generate
    if (DEPTH < 2 || (DEPTH & (DEPTH - 1)) != 0) begin : g_depth_check
      $error("if_id_queue: DEPTH must be a power of two and at least 2");
    end
  endgenerate

  if_id_reg_t       mem [DEPTH];
  logic [PTR_W-1:0] rptr;
  logic [PTR_W-1:0] wptr;
  logic             full;
  logic             empty;
  logic             push;
  logic             pop;

  assign full     = (count == CNT_W'(DEPTH));
  assign empty    = (count == '0);
  assign pc_stall = full;

  // Flush outranks both sides: the wrong-path packet is dropped and the head is not consumed.
  assign push = if_in.valid_if_id && !full && !flush;
  assign pop  = !empty && id_ready && !flush;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      rptr  <= '0;
      wptr  <= '0;
      count <= '0;
    end else if (flush) begin
      rptr  <= '0;
      wptr  <= '0;
      count <= '0;
    end else begin
      if (push) wptr <= wptr + PTR_W'(1);
      if (pop)  rptr <= rptr + PTR_W'(1);
      if (push && !pop)      count <= count + CNT_W'(1);
      else if (pop && !push) count <= count - CNT_W'(1);
    end
  end

  // Storage needs no reset; entries are only read while count says they are live.
  always_ff @(posedge clk) begin
    if (push) mem[wptr] <= if_in;
  end

  always_comb begin
    id_out.pc          = '0;
    id_out.instruction = NOP_INSTR;
    id_out.pc_plus4    = '0;
    id_out.valid_if_id = 1'b0;
    if (!empty) begin
      id_out             = mem[rptr];
      id_out.valid_if_id = 1'b1;
    end
  end

endmodule

// File: tb/tb_if_id_queue.sv
// Directed self-checking bench for if_id_queue: reset, fill/full, pop-while-full,
// streaming across pointer wrap, flush, and asynchronous mid-stream reset.
module tb_if_id_queue;
  import riscv_pkg::*;

  localparam int DEPTH = 4;
  localparam int CNT_W = $clog2(DEPTH + 1);

  logic             clk;
  logic             reset;
  if_id_reg_t       if_in;
  logic             flush;
  logic             id_ready;
  if_id_reg_t       id_out;
  logic             pc_stall;
  logic [CNT_W-1:0] count;

  int checks   = 0;
  int failures = 0;

  if_id_queue #(.DEPTH(DEPTH)) dut (
    .clk      (clk),
    .reset    (reset),
    .if_in    (if_in),
    .flush    (flush),
    .id_ready (id_ready),
    .id_out   (id_out),
    .pc_stall (pc_stall),
    .count    (count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Advance one rising edge; outputs are sampled 1 time unit after it.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic vld, input logic [31:0] pc, input logic [31:0] instr);
    if_in.valid_if_id = vld;
    if_in.pc          = pc;
    if_in.instruction = instr;
    if_in.pc_plus4    = pc + 32'd4;
  endtask

  initial begin
    reset    = 1'b0;
    flush    = 1'b0;
    id_ready = 1'b0;
    drive(1'b0, 32'h0, 32'h0);

    // Reset held for three cycles
    repeat (3) step();
    check("rst_count", 64'(count), 64'd0);
    check("rst_stall", 64'(pc_stall), 64'd0);
    check("rst_valid", 64'(id_out.valid_if_id), 64'd0);
    check("rst_instr", 64'(id_out.instruction), 64'h13);
    check("rst_pc", 64'(id_out.pc), 64'd0);
    check("rst_pcp4", 64'(id_out.pc_plus4), 64'd0);

    // First push right after deassertion
    reset = 1'b1;
    drive(1'b1, 32'h0, 32'h0050_0093);
    step();
    check("push1_count", 64'(count), 64'd1);
    check("push1_pc", 64'(id_out.pc), 64'h0);
    check("push1_instr", 64'(id_out.instruction), 64'h0050_0093);
    check("push1_valid", 64'(id_out.valid_if_id), 64'd1);
    check("push1_pcp4", 64'(id_out.pc_plus4), 64'h4);

    // Fill to full
    for (int i = 1; i < 4; i++) begin
      drive(1'b1, 32'(i * 4), 32'h0000_0013 + 32'(i << 20));
      step();
    end
    check("full_count", 64'(count), 64'd4);
    check("full_stall", 64'(pc_stall), 64'd1);

    // Packet presented while full is ignored
    drive(1'b1, 32'h10, 32'h0000_0033);
    repeat (2) step();
    check("full_hold_count", 64'(count), 64'd4);
    check("full_hold_head", 64'(id_out.pc), 64'h0);

    // Pop while full: no push on that edge, push on the next
    id_ready = 1'b1;
    step();
    check("popfull_head", 64'(id_out.pc), 64'h4);
    check("popfull_count", 64'(count), 64'd3);
    check("popfull_stall", 64'(pc_stall), 64'd0);
    step();
    check("popfull2_count", 64'(count), 64'd3);
    check("popfull2_head", 64'(id_out.pc), 64'h8);

    // Drain with bubbles on if_in: bubbles must not be stored
    drive(1'b0, 32'hDEAD_0000, 32'h0);
    step();
    check("drain_head_c", 64'(id_out.pc), 64'hC);
    step();
    check("drain_head_10", 64'(id_out.pc), 64'h10);
    check("drain_instr_10", 64'(id_out.instruction), 64'h0000_0033);
    step();
    check("drain_count", 64'(count), 64'd0);
    check("drain_valid", 64'(id_out.valid_if_id), 64'd0);

    // Streaming 16 packets with id_ready=1: pointers wrap four times
    for (int i = 0; i < 16; i++) begin
      drive(1'b1, 32'(i * 4), 32'h1000_0000 + 32'(i));
      step();
      check($sformatf("stream_pc_%0d", i), 64'(id_out.pc), 64'(i * 4));
      check($sformatf("stream_instr_%0d", i), 64'(id_out.instruction), 64'h1000_0000 + 64'(i));
      check($sformatf("stream_cnt_%0d", i), 64'(count), 64'd1);
    end
    drive(1'b0, 32'h0, 32'h0);
    step();
    check("stream_end_count", 64'(count), 64'd0);

    // Load 0x20,0x24,0x28 then flush with wrong-path 0x2C and id_ready=1
    id_ready = 1'b0;
    for (int i = 0; i < 3; i++) begin
      drive(1'b1, 32'h20 + 32'(i * 4), 32'h0000_0093);
      step();
    end
    check("preflush_count", 64'(count), 64'd3);
    check("preflush_head", 64'(id_out.pc), 64'h20);
    drive(1'b1, 32'h2C, 32'h0000_0093);
    id_ready = 1'b1;
    flush    = 1'b1;
    step();
    flush = 1'b0;
    drive(1'b0, 32'h0, 32'h0);
    check("flush_count", 64'(count), 64'd0);
    check("flush_valid", 64'(id_out.valid_if_id), 64'd0);
    check("flush_instr", 64'(id_out.instruction), 64'h13);
    check("flush_stall", 64'(pc_stall), 64'd0);

    // Branch target pushed normally after flush
    id_ready = 1'b0;
    drive(1'b1, 32'h100, 32'h0010_0113);
    step();
    check("target_pc", 64'(id_out.pc), 64'h100);
    check("target_valid", 64'(id_out.valid_if_id), 64'd1);
    check("target_count", 64'(count), 64'd1);

    // Async reset between edges with count=2
    drive(1'b1, 32'h104, 32'h0010_0113);
    step();
    check("prerst_count", 64'(count), 64'd2);
    drive(1'b0, 32'h0, 32'h0);
    #2;
    reset = 1'b0;
    #1;
    check("arst_count", 64'(count), 64'd0);
    check("arst_stall", 64'(pc_stall), 64'd0);
    check("arst_valid", 64'(id_out.valid_if_id), 64'd0);
    check("arst_instr", 64'(id_out.instruction), 64'h13);

    // Deassert between edges; first edge accepts a push
    reset = 1'b1;
    drive(1'b1, 32'h200, 32'h0020_0193);
    step();
    check("postrst_count", 64'(count), 64'd1);
    check("postrst_pc", 64'(id_out.pc), 64'h200);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/if_id_queue.md
Name: if_id_queue

Overview:
- Receiving end of the fetch-to-decode interface: accepts if_id_reg_t packets from the fetch stage and buffers them in a small in-order queue.
- Presents the head packet to the decode stage with a valid/ready handshake.
- Produces the pc_stall back-pressure that the fetch stage consumes.
- Discards all buffered wrong-path packets when EX resolves a taken branch.

Parameters:
- DEPTH, 4, number of queue entries; power of two, minimum 2.
- CNT_W, $clog2(DEPTH+1), width of the occupancy count (derived; do not override).

Ports:
- clk  in  1  core clock, rising edge.
- reset  in  1  asynchronous, active-low reset (0 = reset asserted).
- if_in  in  if_id_reg_t  packet from fetch: pc, instruction, pc_plus4, valid_if_id.
- flush  in  1  taken-branch flush from EX (same signal as fetch's branch_taken).
- id_ready  in  1  decode can accept the head packet this cycle; low on hazard stall.
- id_out  out  if_id_reg_t  head packet to decode; id_out.valid_if_id = queue non-empty.
- pc_stall  out  1  to fetch; high when the queue is full, so fetch holds PC and if_in.
- count  out  CNT_W  current occupancy, 0..DEPTH.

Behaviour:
- Storage: DEPTH-entry array of if_id_reg_t, plus read pointer, write pointer (log2(DEPTH) bits, natural wrap) and count register.
- Reset (reset=0, asynchronous):
  - Pointers and count clear to 0 immediately; pc_stall=0.
  - id_out.valid_if_id=0; id_out.pc=0, pc_plus4=0, instruction=NOP_INSTR (32'h0000_0013).
  - Array contents are don't-care.
- push = if_in.valid_if_id && !full && !flush
  - Writes if_in at wptr on the rising edge; wptr+1.
- pop = !empty && id_ready && !flush
  - Advances rptr+1 on the rising edge.
- count update:
  - push only: +1. pop only: -1. Both: unchanged. Neither: unchanged.
- Output:
  - id_out is driven combinationally from array[rptr] when count!=0.
  - When empty, id_out is the reset/NOP pattern above with valid_if_id=0.
- Latency:
  - A packet pushed at edge N is visible on id_out after edge N, i.e. in cycle N+1.
  - There is no same-cycle bypass from if_in to id_out.
- Full:
  - full = (count==DEPTH); pc_stall = full, a function of registered state only.
  - While full, if_in is ignored even if pop occurs in the same cycle. Fetch holds PC, so the same packet is re-presented and accepted the next cycle.
- Empty + push + id_ready: push only. The new packet is visible next cycle; no pop occurs.
- Flush (synchronous, priority over push and pop):
  - At the edge: rptr=wptr=0 and count=0.
  - The if_in packet present in the flush cycle is dropped (wrong path).
  - The head packet is not consumed in the flush cycle, even if id_ready=1.
  - Cycle after flush: queue empty, pc_stall=0, and the branch-target packet from fetch is pushed normally.
- Wrap-around: pointers wrap modulo DEPTH with no special casing. Full and empty are distinguished by count, not by pointer equality.
- valid_if_id=0 on if_in is never stored, so bubbles do not occupy entries.
- Reset asserted mid-operation behaves exactly like power-on reset. Deassertion has no extra latency: pushes are accepted on the first edge with reset=1.

Decomposition:
- riscv_pkg: if_id_reg_t (existing), XLEN (existing), and new NOP_INSTR = 32'h0000_0013 (addi x0,x0,0).
- No sub-module. Pointer, count and array logic are inline; a generic FIFO would hide the flush priority and NOP output rules.
- Lint: DEPTH power-of-two check via an elaboration-time assertion.

Test Plan:
- Reset then 1 push: hold reset=0 3 cycles; drive if_in={pc=0x0,instr=0x00500093,valid=1}, id_ready=0 -> after one edge count=1, id_out.pc=0x0, id_out.instruction=0x00500093, valid=1.
- Fill to full: id_ready=0, push pc=0x0,0x4,0x8,0xC -> count=4, pc_stall=1.
  - Then present pc=0x10 for 2 cycles -> not stored; count stays 4.
- Pop while full: from full with id_ready=1 and if_in pc=0x10 held -> edge1: head becomes 0x4, count=3, pc_stall=0; edge2: 0x10 pushed, count=3.
- Streaming with wrap: id_ready=1, continuous pushes pc=0x0..0x3C (16 packets) -> id_out.pc sequence 0x0,0x4,…,0x3C in order, each one cycle after its push; count settles at 1; no loss across pointer wrap.
- Flush: count=3 holding 0x20,0x24,0x28; assert flush with if_in pc=0x2C, id_ready=1 -> next cycle count=0, valid=0, instruction=0x00000013.
  - Then push target pc=0x100 -> visible next cycle.
- Async reset mid-stream: assert reset=0 between clock edges with count=2 -> count=0, pc_stall=0, id_out.valid_if_id=0 immediately, without waiting for a clock edge.
